// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit in the EX stage. Operands
//            and funct3 come straight from ID/EX; the 32-bit result feeds the
//            EX result mux. One multiply/divide step is done per cycle.
// Ports    : clk     - clock, rising edge
//            rst_n   - reset, asynchronous, active-high (historical name)
//            flush   - synchronous abort back to IDLE, beats start
//            start   - M-extension instruction valid in EX
//            op      - funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//            opA/opB - rs1/rs2 after forwarding
//            busy    - combinational stall request to the hazard unit
//            done    - registered one-cycle completion pulse
//            result  - registered result, held until the next completion
// Config   : MULDIV_DIV_EN - when defined, builds the restoring divider;
//            otherwise ops 4-7 complete on the fast path with result 0.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [4:0]          cnt;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_mag;
    logic                neg_res;

    // Multiply accumulator: upper half collects partial sums, lower half
    // starts as the multiplier and is shifted out one bit per step.
    logic [2*XLEN-1:0]   acc, acc_nx, prod_fin;
    logic [XLEN:0]       mul_sum;

    logic                a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic                fast;
    logic [XLEN-1:0]     fast_res, calc_res;
    logic                last;

    always_comb begin
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sign_a   = a_signed & opA[XLEN-1];
        sign_b   = b_signed & opB[XLEN-1];
        a_abs    = sign_a ? -opA : opA;
        b_abs    = sign_b ? -opB : opB;
    end

    assign last = (state == S_CALC) && (cnt == 5'd31);

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
        acc_nx   = {mul_sum, acc[XLEN-1:1]};
        prod_fin = neg_res ? -acc_nx : acc_nx;
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0]     b_mag;
    logic                neg_rem;
    logic [XLEN:0]       rem, rem_nx;
    logic [XLEN-1:0]     quo, quo_nx, q_fin, r_fin;
    logic [XLEN+1:0]     shifted, diff;

    // Restoring step: bring in the next dividend bit (MSB first, taken from
    // the top of quo), trial-subtract, keep the difference if no borrow.
    // Quotient bits shift into quo from the bottom as dividend bits leave.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {2'b00, b_mag};
        rem_nx  = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
        quo_nx  = {quo[XLEN-2:0], ~diff[XLEN+1]};
        q_fin   = neg_res ? -quo_nx : quo_nx;
        r_fin   = neg_rem ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
    end

    // Divide by zero and signed overflow bypass the loop entirely.
    always_comb begin
        fast     = 1'b0;
        fast_res = '0;
        if (op[2]) begin
            if (opB == '0) begin
                fast     = 1'b1;
                fast_res = op[1] ? opA : '1;
            end else if (!op[0] && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1)) begin
                fast     = 1'b1;
                fast_res = op[1] ? '0 : opA;
            end
        end
    end

    always_comb begin
        if (op_q[2])
            calc_res = op_q[1] ? r_fin : q_fin;
        else if (op_q == 3'd0)
            calc_res = prod_fin[XLEN-1:0];
        else
            calc_res = prod_fin[2*XLEN-1:XLEN];
    end
`else
    // No divider: every divide/remainder op completes immediately with 0.
    assign fast     = op[2];
    assign fast_res = '0;
    assign calc_res = (op_q == 3'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = fast ? S_DONE : S_CALC;
            S_CALC:  if (last)  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    assign busy = ((state == S_IDLE) && start && !flush) || (state == S_CALC);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            done    <= 1'b0;
            result  <= '0;
            op_q    <= 3'd0;
            a_mag   <= '0;
            neg_res <= 1'b0;
            acc     <= '0;
`ifdef MULDIV_DIV_EN
            b_mag   <= '0;
            neg_rem <= 1'b0;
            rem     <= '0;
            quo     <= '0;
`endif
        end else begin
            state <= state_nx;
            done  <= (state_nx == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q    <= op;
                        a_mag   <= a_abs;
                        neg_res <= sign_a ^ sign_b;
                        cnt     <= 5'd0;
                        acc     <= {{XLEN{1'b0}}, b_abs};
`ifdef MULDIV_DIV_EN
                        b_mag   <= b_abs;
                        neg_rem <= sign_a;
                        rem     <= '0;
                        quo     <= a_abs;
`endif
                        if (fast) result <= fast_res;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        acc <= acc_nx;
`ifdef MULDIV_DIV_EN
                        rem <= rem_nx;
                        quo <= quo_nx;
`endif
                        cnt <= cnt + 5'd1;
                        // Sign correction happens on the final step.
                        if (last) result <= calc_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Self-checking bench for ex_muldiv_unit: directed cases, random
//            operations against an arithmetic reference, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .op(op),
        .opA(opA), .opB(opB), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] pr, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        pr = '0;
        q  = 0;
        case (o)
            3'd0: begin pr = ua * ub; return pr[31:0]; end
            3'd1: begin pr = sa * sb; return pr[63:32]; end
            3'd2: begin pr = sa * ub; return pr[63:32]; end
            3'd3: begin pr = ua * ub; return pr[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; return q[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            3'd6: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
            3'd7: begin if (b == 0) return a; return a % b; end
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        if (o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`else
        if (o[2]) return 1;
`endif
        return 33;
    endfunction

    // Issue one op the way the pipeline does: start stays high while the
    // instruction sits in EX and drops once the DONE cycle is over.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          bcnt;
        bit          got;
        logic [31:0] exp;
        exp  = model(o, a, b);
        bcnt = 0;
        got  = 0;
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (busy) bcnt++;
            if (done) got = 1;
            else @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy(o, a, b)));
        start = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 200));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          saw_done;
        logic [31:0] held;

        // Reset state, busy follows start while held in IDLE
        repeat (2) @(negedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy_lo", {31'b0, busy}, 32'd0);
        start = 1'b1;
        #1;
        chk("rst_busy_hi", {31'b0, busy}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;

        // Directed cases
        run_op("mul_7_m3",   3'd0, 32'd7, 32'hFFFFFFFD);
        run_op("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'd2);
        run_op("mulh_neg",   3'd1, 32'h80000000, 32'h7FFFFFFF);
        run_op("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2);
        run_op("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
        run_op("div_by0",    3'd4, 32'd5, 32'd0);
        run_op("rem_by0",    3'd6, 32'd5, 32'd0);
        run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF);
        run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF);
        run_op("divu_9_3",   3'd5, 32'd9, 32'd3);

        // Random operations
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op($sformatf("rnd%0d_op%0d", k, ro), ro, ra, rb);
        end

        // Flush in CALC cycle 10
        run_op("pre_flush", 3'd0, 32'd6, 32'd7);
        held = result;
        @(negedge clk);
        start = 1'b1; op = 3'd0; opA = 32'd1000; opB = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done) saw_done = 1;
        end
        chk("flush_no_done", 32'(saw_done), 32'd0);
        chk("flush_result_held", result, held);
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4);

        // Reset pulse mid-CALC
        @(negedge clk);
        start = 1'b1; op = 3'd0; opA = 32'd5; opB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        run_op("post_rst_mul", 3'd0, 32'd11, 32'd13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It takes operands and funct3 straight from the ID/EX pipeline register and returns a 32-bit result to the EX result mux. While an operation is in progress it raises `busy`, which the hazard unit uses to hold PC, IF/ID and ID/EX.

## Interface
- `XLEN`, 32: operand/result width; only 32 supported.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous abort; returns the unit to IDLE.
- `start`  in  1  M-extension instruction valid in EX (ID/EX ctrl bit).
- `op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `opA`  in  32  rs1 operand, after forwarding.
- `opB`  in  32  rs2 operand, after forwarding.
- `busy`  out  1  combinational stall request.
- `done`  out  1  registered; high for exactly one cycle while `result` is valid.
- `result`  out  32  registered result; holds its value until the next completion.

## Operation
- States:
  - IDLE: no operation in progress.
  - CALC: iterative loop; 5-bit counter `cnt` runs 0..31.
  - DONE: result presented.
- IDLE, `start`=1, normal case: latch operand magnitudes, sign flags and op; `cnt`<=0; go to CALC.
- IDLE, `start`=1, fast case: compute the result directly; go to DONE. Fast cases:
  - divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give opA.
  - signed overflow, opA=0x80000000 and opB=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle. Go to DONE when `cnt`==31 and that iteration completes.
- DONE: assert `done` and drive `result`; go to IDLE unconditionally. `start` is ignored in DONE.
- Signedness:
  - opA is treated as signed for MULH, MULHSU, DIV and REM.
  - opB is treated as signed for MULH, DIV and REM.
  - The unit works on magnitudes and applies the sign correction on entry to DONE.
- Multiply: shift-add into a 64-bit accumulator. The product is negated if the operand signs differ. MUL returns [31:0]; MULH, MULHSU and MULHU return [63:32].
- Divide: restoring division with a 33-bit partial remainder, one quotient bit per cycle, MSB first.
  - Quotient sign = sign(opA) XOR sign(opB).
  - Remainder sign = sign(opA).
- Flush:
  - Forces IDLE in any state; `done` deasserts on the next edge.
  - `result` is not updated.
  - `flush` has priority over `start`.
- Reset: state IDLE, `cnt`=0, `done`=0, `result`=0, internal datapath registers cleared. `busy` equals `start` while held in IDLE.

## Timing
- `busy` = (IDLE and `start` and not `flush`) or CALC. It is combinational, so ID/EX holds on the acceptance cycle.
- Normal op: accept at edge E0, 32 CALC cycles, DONE during the cycle after E32.
  - `busy` is high for 33 cycles.
  - The instruction occupies EX for 34 cycles.
- Fast op: `busy` is high for 1 cycle, DONE in the next cycle; 2 cycles in EX.
- The pipeline advances at the end of the DONE cycle, because `busy` is low during DONE. EX/MEM captures `result` at that edge.
- Back-to-back M ops: the next `start` is seen in IDLE one cycle after DONE. Minimum spacing is no bubble beyond DONE.
- Reset mid-CALC: immediate return to IDLE; the partial result is discarded.

## Configuration
- `MULDIV_DIV_EN` defined: all eight ops are implemented as above.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath and its remainder register are not built.
  - Ops 4-7 take the fast path and return 0 with the 2-cycle timing.
  - Multiply behaviour is unchanged.

## Test plan
- MUL opA=7, opB=-3 (0xFFFFFFFD) -> `busy` high 33 cycles, then `done` pulse with `result`=0xFFFFFFEB.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> `result`=0xFFFFFFFE. MULHSU opA=-1, opB=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV opB=0, opA=5 -> 1-cycle `busy`, `result`=0xFFFFFFFF; REM gives 5. DIV 0x80000000/-1 -> 0x80000000; REM gives 0.
- `flush` in CALC cycle 10 -> IDLE next edge, no `done`, `result` unchanged. A following MUL 3x4 gives 12.
- `rst_n` pulse in CALC -> `done`=0 and `result`=0 immediately. With `MULDIV_DIV_EN` undefined, DIVU 9/3 -> `result`=0 in 2 cycles.
